// File: rtl/poseidon_stream_pkg.sv
// Shared types for the Poseidon output stream: beat layout and sink FSM states.
package poseidon_stream_pkg;
  localparam int DATA_W = 255;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] payload;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sink_state_t;
endpackage

// File: rtl/poseidon_sink_fifo.sv
// First-word-fall-through FIFO of stream beats; head is visible whenever not empty.
module poseidon_sink_fifo
  import poseidon_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  beat_t                    wdata,
  input  logic                     pop,
  output beat_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  beat_t       mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_pop;

  // Pointers carry one extra wrap bit so the difference is the occupancy.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign do_pop = pop && !empty;
  assign rdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)        rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/poseidon_output_sink.sv
// Stream sink with programmable backpressure, beat/frame counting and stop-at-target.
// Define POSEIDON_SINK_PROTO_CHECK_EN to build the valid/payload hold checker (err_proto).
module poseidon_output_sink
  import poseidon_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   io_input_valid,
  output logic                   io_input_ready,
  input  logic                   io_input_last,
  input  logic [DATA_W-1:0]      io_input_payload,
  input  logic                   enable,
  input  logic [3:0]             stall_mask,
  input  logic [7:0]             frames_target,
  input  logic                   rd_en,
  output beat_t                  rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            beat_count,
  output logic [7:0]             frame_count,
  output logic                   done,
  output logic                   err_proto
);
  sink_state_t state_q, state_d;
  logic [1:0]  phase_q;
  logic        full, fire, start, hit_target;
  beat_t       in_beat;

  assign in_beat        = '{last: io_input_last, payload: io_input_payload};
  assign io_input_ready = (state_q == S_RUN) && !full && !stall_mask[phase_q];
  assign fire           = io_input_valid && io_input_ready;
  assign start          = (state_q == S_IDLE) && enable;
  assign hit_target     = fire && io_input_last && (frames_target != 8'd0) &&
                          (frame_count + 8'd1 == frames_target);
  assign done           = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      // Reaching the target wins over a simultaneous enable drop; DONE then exits.
      S_RUN:   if (hit_target) state_d = S_DONE;
               else if (!enable) state_d = S_IDLE;
      S_DONE:  if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      beat_count  <= '0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        phase_q     <= '0;
        beat_count  <= '0;
        frame_count <= '0;
      end else begin
        if (state_q == S_RUN) phase_q <= phase_q + 2'd1;
        if (fire) begin
          beat_count <= beat_count + 16'd1;
          if (io_input_last) frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  poseidon_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fire),
    .wdata  (in_beat),
    .pop    (rd_en),
    .rdata  (rd_data),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

`ifdef POSEIDON_SINK_PROTO_CHECK_EN
  logic  hold_q, err_q;
  beat_t held_q;

  // A beat offered but refused while running must be re-offered unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= 1'b0;
      held_q <= '0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= io_input_valid && !io_input_ready && (state_q == S_RUN);
      held_q <= in_beat;
      if (start) err_q <= 1'b0;
      else if (hold_q && (!io_input_valid || in_beat != held_q)) err_q <= 1'b1;
    end
  end
  assign err_proto = err_q;
`else
  assign err_proto = 1'b0;
`endif
endmodule

// File: tb/tb_poseidon_output_sink.sv
// Self-checking bench: stall-pattern table, queue-based reference model, corner sequences.
module tb_poseidon_output_sink;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         io_input_valid, io_input_ready, io_input_last;
  logic [254:0] io_input_payload;
  logic         enable, rd_en, empty, done, err_proto;
  logic [3:0]   stall_mask;
  logic [7:0]   frames_target, frame_count;
  logic [255:0] rd_data;
  logic [4:0]   level;
  logic [15:0]  beat_count;

  poseidon_output_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .io_input_valid(io_input_valid), .io_input_ready(io_input_ready),
    .io_input_last(io_input_last), .io_input_payload(io_input_payload),
    .enable(enable), .stall_mask(stall_mask), .frames_target(frames_target),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .level(level),
    .beat_count(beat_count), .frame_count(frame_count), .done(done),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

`ifdef POSEIDON_SINK_PROTO_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int tests = 0, fails = 0;

  // Reference model: sink mode (0 idle, 1 running, 2 finished), buffer as a queue.
  int           mode, runcyc, beats, frames;
  logic         m_err, pend;
  logic [255:0] saved;
  logic [255:0] q[$];
  logic [255:0] txq[$];
  int           gap_pct, rd_pct;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] rdy;   // expected ready for phases 3..0
  } tbl_t;
  tbl_t tbl[4];

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; runcyc = 0; beats = 0; frames = 0; m_err = 0; pend = 0; saved = '0;
    q.delete();
  endtask

  function automatic logic [255:0] rnd_beat(input logic l);
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    t[255] = l;
    return t;
  endfunction

  task automatic check_outputs();
    chk("empty", empty, q.size() == 0);
    chk("level", level, q.size());
    chk("beat_count", beat_count, beats % 65536);
    chk("frame_count", frame_count, frames);
    chk("done", done, mode == 2);
    chk("err_proto", err_proto, m_err);
    chk("rd_data", rd_data, (q.size() > 0) ? q[0] : 256'd0);
  endtask

  task automatic step();
    logic         exp_rdy, v, fire, pop;
    logic [255:0] b;
    v = io_input_valid;
    b = {io_input_last, io_input_payload};
    exp_rdy = (mode == 1) && (q.size() < DEPTH) && !stall_mask[runcyc % 4];
    chk("ready", io_input_ready, exp_rdy);
    fire = v && exp_rdy;
    pop  = rd_en && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (fire) begin
      q.push_back(b);
      beats++;
      if (b[255]) frames = (frames + 1) % 256;
    end
`ifdef POSEIDON_SINK_PROTO_CHECK_EN
    if (mode == 0 && enable) m_err = 0;
    else if (pend && (!v || b != saved)) m_err = 1;
    pend  = v && !exp_rdy && (mode == 1);
    saved = b;
`endif
    case (mode)
      0: if (enable) begin mode = 1; runcyc = 0; beats = 0; frames = 0; end
      1: begin
        runcyc++;
        if (fire && b[255] && frames_target != 0 && frames == frames_target) mode = 2;
        else if (!enable) mode = 0;
      end
      default: if (!enable) mode = 0;
    endcase
    #1;
    if (!(v && !fire)) begin
      if (txq.size() > 0 && $urandom_range(99) >= gap_pct) begin
        b = txq.pop_front();
        {io_input_last, io_input_payload} = b;
        io_input_valid = 1'b1;
      end else begin
        io_input_valid = 1'b0;
      end
    end
    rd_en = ($urandom_range(99) < rd_pct);
    check_outputs();
  endtask

  task automatic restart(input logic [3:0] m, input logic [7:0] t, input int rp);
    int g = 0;
    io_input_valid = 0; txq.delete();
    enable = 0; rd_pct = 100; rd_en = 1;
    step(); step();
    while (q.size() > 0 && g < 64) begin step(); g++; end
    stall_mask = m; frames_target = t; rd_pct = rp; enable = 1;
    step();
  endtask

  task automatic run_tx(input int maxc);
    int c = 0;
    while ((txq.size() > 0 || io_input_valid) && c < maxc) begin step(); c++; end
    chk("timeout", c < maxc, 1'b1);
  endtask

  initial begin
    tbl[0] = '{mask: 4'b0000, rdy: 4'b1111};
    tbl[1] = '{mask: 4'b1010, rdy: 4'b0101};
    tbl[2] = '{mask: 4'b1111, rdy: 4'b0000};
    tbl[3] = '{mask: 4'b0110, rdy: 4'b1001};

    resetn = 0; io_input_valid = 0; io_input_last = 0; io_input_payload = '0;
    enable = 0; stall_mask = 0; frames_target = 0; rd_en = 0;
    gap_pct = 0; rd_pct = 0;
    model_reset();
    #8;
    chk("rst_ready", io_input_ready, 1'b0);
    chk("rst_rd_data", rd_data, 256'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_level", level, 0);
    chk("rst_beats", beat_count, 0);
    chk("rst_frames", frame_count, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_proto, 1'b0);
    #4 resetn = 1;
    @(posedge clk); #1;

    // Ready pattern per phase for several stall masks.
    foreach (tbl[i]) begin
      restart(tbl[i].mask, 8'd0, 100);
      for (int p = 0; p < 4; p++) begin
        chk("tbl_ready", io_input_ready, tbl[i].rdy[p]);
        step();
      end
    end

    // Unstalled run to a 10-frame target.
    restart(4'b0000, 8'd10, 100); gap_pct = 0;
    for (int i = 0; i < 30; i++) txq.push_back(rnd_beat(i % 3 == 2));
    run_tx(100);
    chk("t1_frames", frame_count, 8'd10);
    chk("t1_beats", beat_count, 16'd30);
    chk("t1_done", done, 1'b1);
    step();
    chk("t1_ready_after", io_input_ready, 1'b0);

    // Stall on phases 1 and 3 with random reads and source gaps.
    restart(4'b1010, 8'd10, 50); gap_pct = 20;
    for (int i = 0; i < 30; i++) txq.push_back(rnd_beat(i % 3 == 2));
    run_tx(400);
    chk("t2_beats", beat_count, 16'd30);
    chk("t2_done", done, 1'b1);

    // Fill to full with no reads, then a single pop.
    restart(4'b0000, 8'd0, 0); gap_pct = 0;
    for (int i = 0; i < 20; i++) txq.push_back(rnd_beat(1'b0));
    for (int c = 0; c < 40 && level != 5'd16; c++) step();
    chk("t3_level_full", level, 5'd16);
    chk("t3_ready_full", io_input_ready, 1'b0);
    rd_en = 1; step();
    chk("t3_ready_back", io_input_ready, 1'b1);
    step();
    chk("t3_beat17", beat_count, 16'd17);
    chk("t3_level_again", level, 5'd16);
    rd_pct = 100;
    run_tx(100);

    // Source withdraws a refused beat.
    restart(4'b1111, 8'd0, 100);
    io_input_valid = 1; io_input_last = 0; io_input_payload = rnd_beat(1'b0);
    step();
    io_input_valid = 0;
    step();
    chk("t4_err_set", err_proto, ERR_EXP);
    step(); step();
    chk("t4_err_sticky", err_proto, ERR_EXP);
    restart(4'b0000, 8'd0, 100);
    chk("t4_err_clear", err_proto, 1'b0);

    // Unlimited target: 256 single-beat frames wrap the frame counter.
    restart(4'b0000, 8'd0, 100); gap_pct = 0;
    for (int i = 0; i < 256; i++) txq.push_back(rnd_beat(1'b1));
    run_tx(400);
    chk("t5_frames_wrap", frame_count, 8'd0);
    chk("t5_beats", beat_count, 16'd256);
    chk("t5_no_done", done, 1'b0);

    // Asynchronous reset mid-frame.
    restart(4'b0000, 8'd0, 30); gap_pct = 10;
    for (int i = 0; i < 10; i++) txq.push_back(rnd_beat(1'b0));
    for (int c = 0; c < 60 && beats < 5; c++) step();
    #2 resetn = 0;
    #1;
    chk("t6_ready", io_input_ready, 1'b0);
    chk("t6_rd_data", rd_data, 256'd0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_level", level, 0);
    chk("t6_beats", beat_count, 0);
    chk("t6_frames", frame_count, 0);
    chk("t6_done", done, 1'b0);
    chk("t6_err", err_proto, 1'b0);
    model_reset();
    io_input_valid = 0; txq.delete(); enable = 0;
    #2 resetn = 1;
    restart(4'b0000, 8'd0, 100); gap_pct = 0;
    for (int i = 0; i < 3; i++) txq.push_back(rnd_beat(i == 2));
    run_tx(50);
    chk("t6_restart_beats", beat_count, 16'd3);
    chk("t6_restart_frames", frame_count, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/poseidon_output_sink.md
# poseidon_output_sink

Synthesizable stream sink that terminates the Poseidon output stream (valid/ready/last/255-bit payload) opposite the input-side stimulus driver. Accepts beats under programmable backpressure, buffers them with their `last` flag in a first-word-fall-through buffer, counts beats and frames, and stops after a target frame count. Used in simulation benches and FPGA loopback tests to collect hash results with the full ready/valid contract exercised.

## Interface
- `DATA_W`, 255, payload width.
- `DEPTH`, 16, buffer entries, power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `io_input_valid`  in  1  upstream beat valid.
- `io_input_ready`  out  1  sink can accept.
- `io_input_last`  in  1  final beat of frame.
- `io_input_payload`  in  DATA_W  beat data.
- `enable`  in  1  level; high runs the sink.
- `stall_mask`  in  4  per-phase ready suppression pattern.
- `frames_target`  in  8  frames to accept; 0 = unlimited.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  DATA_W+1  head entry, {last, payload}.
- `empty`  out  1  buffer empty.
- `level`  out  $clog2(DEPTH)+1  occupancy.
- `beat_count`  out  16  accepted beats, wraps.
- `frame_count`  out  8  accepted `last` beats.
- `done`  out  1  target reached.
- `err_proto`  out  1  sticky protocol violation.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE: ready low. `enable`=1 → RUN; the rising-edge cycle clears beat_count, frame_count, phase, err_proto (buffer contents kept).
- RUN: `io_input_ready = !full && !stall_mask[phase]`. 2-bit phase increments every RUN cycle, wraps 3→0.
- Handshake = valid && ready at posedge: {last, payload} written, beat_count+1; if last, frame_count+1.
- Accepted last where frame_count+1 == frames_target (target≠0) → DONE next cycle. Target 0: never DONE, frame_count wraps 255→0.
- DONE: ready low, `done`=1. `enable`=0 → IDLE.
- RUN with `enable`=0 → IDLE immediately; an in-flight beat not yet accepted is not taken.
- Buffer FWFT: `rd_data` valid whenever !empty; `rd_en` pops on posedge; `rd_en` on empty ignored.
- Full: ready low from full alone; simultaneous pop does not re-enable ready in the same cycle.
- Push and pop same cycle (not full, not empty): level unchanged.

## Timing
- `io_input_ready` combinational from registered state, full, phase and `stall_mask` only; never depends on `io_input_valid`.
- Accepted beat: `empty` deasserts and `level` increments the following cycle.
- `done` asserts the cycle after the final accepted last.
- Reset values: ready 0, rd_data 0, empty 1, level 0, beat_count 0, frame_count 0, done 0, err_proto 0.
- Asynchronous reset mid-frame: state, counters, pointers cleared at once; buffer contents discarded.

## Configuration
- `POSEIDON_SINK_PROTO_CHECK_EN` defined: while valid && !ready, next cycle must hold valid=1 with unchanged payload and last; violation sets `err_proto` (sticky until reset or enable rise). Also flags valid with X/unknown-free check omitted.
- Undefined: checker not built, `err_proto` tied 0.

## Structure
- Package `poseidon_stream_pkg`: `DATA_W` constant, `beat_t` packed {last, payload}, sink FSM state enum.
- One sub-module `poseidon_sink_fifo`: FWFT synchronous FIFO, DEPTH entries of `beat_t`, full/empty/level; FSM, counters and checker in top.

## Test plan
- stall_mask=0, target=10, 30 beats with last every 3rd, no stalls → ready high throughout, frame_count=10, beat_count=30, done the cycle after beat 30, then ready 0.
- stall_mask=4'b1010 → ready low on phases 1 and 3 exactly; all 30 beats captured in order with correct last bits.
- No reads, DEPTH=16, 20 beats offered → ready drops after 16th accept, level=16; one rd_en → ready returns the next cycle, 17th beat accepted.
- Source drops valid while stalled (proto check built) → err_proto=1 and stays; enable re-rise clears it. Without macro → err_proto 0.
- target=0, 256 single-beat frames → frame_count wraps to 0, done never asserts.
- resetn low after beat 5 of a frame → all outputs to reset values asynchronously; after release and enable, counting restarts from 0.
